// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding, default width and counter sizing for seq_divider.
package seq_div_pkg;
    localparam int DIV_W = 4;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    localparam int DIV_CNT_W = cnt_width(DIV_W);
endpackage

// File: rtl/ripple_sub.sv
// ripple_sub: WIDTH+1 bit ripple-borrow subtractor of full-subtractor cells; bout=1 when a<b.
module ripple_sub
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           bout
);
    logic [WIDTH+1:0] bw;
    assign bw[0] = 1'b0;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
    assign bout = bw[WIDTH+1];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
// DIV_EARLY_ZERO_EN: a zero divisor at accept skips iteration and signals done one cycle later.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             err
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] d, r, q, dvs_q, r_nx, q_nx;
    logic [WIDTH:0] p, t;
    logic bout, accept, last, skip, unused_msb;

    assign p = {r, d[WIDTH-1]};
    ripple_sub #(.WIDTH(WIDTH)) u_sub (
        .a(p),
        .b({1'b0, dvs_q}),
        .diff(t),
        .bout(bout)
    );
    // the remainder never exceeds the divisor, so the top difference bit carries nothing
    assign unused_msb = t[WIDTH];
    assign r_nx = bout ? p[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_nx = {q[WIDTH-2:0], ~bout};
    assign busy = state == S_RUN;
    assign done = state == S_DONE;

    always_comb begin
        accept = start && state != S_RUN;
        last   = state == S_RUN && cnt == CW'(WIDTH - 1);
`ifdef DIV_EARLY_ZERO_EN
        skip   = accept && dvs == '0;
`else
        skip   = 1'b0;
`endif
        state_nx = skip ? S_DONE : accept ? S_RUN : state == S_RUN ? (last ? S_DONE : S_RUN) : S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            d     <= '0;
            r     <= '0;
            q     <= '0;
            dvs_q <= '0;
            quot  <= '0;
            rem   <= '0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                d     <= dvd;
                dvs_q <= dvs;
                r     <= '0;
                q     <= '0;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                d   <= {d[WIDTH-2:0], 1'b0};
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                quot <= q_nx;
                rem  <= r_nx;
                err  <= dvs_q == '0;
            end
            if (skip) begin
                quot <= '1;
                rem  <= dvd;
                err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider against a cycle-level arithmetic model.
// Honours DIV_EARLY_ZERO_EN for zero-divisor latency and busy expectations.
module tb_seq_divider;
    localparam int W = 4;
`ifdef DIV_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] dvd = '0, dvs = '0;
    logic busy, done, err;
    logic [W-1:0] quot, rem;
    int checks = 0, errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .dvd(dvd), .dvs(dvs),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // {err, quot, rem} straight from the arithmetic definition
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return {1'b1, {W{1'b1}}, a};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    // model: cycles of busy left, done pulse, held results
    int m_left;
    logic m_done, m_err, p_err;
    logic [W-1:0] m_quot, m_rem, p_quot, p_rem;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_left <= 0; m_done <= 0; m_quot <= '0; m_rem <= '0; m_err <= 0;
            p_quot <= '0; p_rem <= '0; p_err <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= m_left == 1;
            if (m_left == 1) begin
                m_quot <= p_quot; m_rem <= p_rem; m_err <= p_err;
            end
        end else if (start) begin
            {p_err, p_quot, p_rem} <= ref_div(dvd, dvs);
            if (EARLY && dvs == 0) begin
                m_done <= 1;
                {m_err, m_quot, m_rem} <= ref_div(dvd, dvs);
            end else begin
                m_left <= W;
                m_done <= 0;
            end
        end else begin
            m_done <= 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        if (m_left == 0) begin
            chk("quot", quot, m_quot);
            chk("rem", rem, m_rem);
            chk("err", err, m_err);
        end
    end

    // issue one start from a point just after an edge; return in the done cycle
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee);
        int n;
        start = 1; dvd = a; dvs = b;
        @(posedge clk); #1;
        start = 0; dvd = W'($urandom); dvs = W'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("res_quot", quot, eq);
        chk("res_rem", rem, er);
        chk("res_err", err, ee);
    endtask

    initial begin
        int dones;
        logic [2*W:0] e;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;

        run(13, 3, 5, 4, 1, 0);
        run(15, 1, 5, 15, 0, 0);
        run(7, 9, 5, 0, 7, 0);
        @(posedge clk); #1;
        run(9, 0, EARLY ? 1 : 5, 15, 9, 1);
        @(posedge clk); #1;

        // start held through busy while operands keep changing
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            start = 1;
            dvd = (i == 0) ? 4'd6 : W'(i);
            dvs = (i == 0) ? 4'd4 : 4'd3;
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    chk("held_quot", quot, 1);
                    chk("held_rem", rem, 2);
                end
            end
        end
        chk("held_dones", dones, 2);
        start = 0;
        repeat (8) @(posedge clk);
        #1;

        // reset in the middle of an 11/2 division
        start = 1; dvd = 11; dvs = 2;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        rstn = 0;
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quot, 0);
        chk("abort_rem", rem, 0);
        chk("abort_err", err, 0);
        @(posedge clk); #1;
        rstn = 1;
        dones = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run(11, 2, 5, 5, 1, 0);

        // every operand pair, back to back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                e = ref_div(W'(a), W'(b));
                run(W'(a), W'(b), (EARLY && b == 0) ? 1 : 5, e[2*W-1:W], e[W-1:0], e[2*W]);
            end
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
